// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_access_stage_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [WORD_W-1:0] data;
        logic              err_misalign;
        logic              err_timeout;
    } wb_t;

endpackage

// File: rtl/mem_access_stage_bus_watchdog.sv
// Bus wait counter; expired flags the last permitted wait cycle.
module bus_watchdog
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one word transfer per instruction on a req/ack bus,
// followed by a single registered write-back beat.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] eff_addr,
    input  logic [WORD_W-1:0] store_data,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [WORD_W-1:0] wb_data,
    output logic              err_misalign,
    output logic              err_timeout,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    mem_state_e        state, state_d;
    wb_t               wb, wb_d;
    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [WORD_W-1:0] wdata_d;
    logic              is_mem, is_store, wd_expired;

    assign is_mem   = mem_read | mem_write;
    assign is_store = mem_write & ~mem_read;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != ST_BUS),
        .enable  ((state == ST_BUS) && !bus_ack),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state;
        wb_d    = '0;
        req_d   = bus_req;
        we_d    = bus_we;
        addr_d  = bus_addr;
        wdata_d = bus_wdata;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_DONE;
                    if (!is_mem) begin
                        wb_d.valid = 1'b1;
                        wb_d.we    = 1'b1;
                        wb_d.data  = alu_result;
                    end else if (eff_addr[1:0] != 2'b00) begin
                        wb_d.valid        = 1'b1;
                        wb_d.err_misalign = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {eff_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = store_data;
                    end
                end
            end
            ST_BUS: begin
                // An ack on the expiry cycle still completes normally
                if (bus_ack) begin
                    state_d    = ST_DONE;
                    req_d      = 1'b0;
                    wb_d.valid = 1'b1;
                    wb_d.we    = ~bus_we;
                    wb_d.data  = bus_we ? '0 : bus_rdata;
                end else if (wd_expired) begin
                    state_d          = ST_DONE;
                    req_d            = 1'b0;
                    wb_d.valid       = 1'b1;
                    wb_d.err_timeout = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wb        <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_d;
            wb        <= wb_d;
            bus_req   <= req_d;
            bus_we    <= we_d;
            bus_addr  <= addr_d;
            bus_wdata <= wdata_d;
        end
    end

    assign stall        = ((state == ST_IDLE) && in_valid) || (state == ST_BUS);
    assign wb_valid     = wb.valid;
    assign wb_we        = wb.we;
    assign wb_data      = wb.data;
    assign err_misalign = wb.err_misalign;
    assign err_timeout  = wb.err_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// transaction-level reference model.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, mem_read, mem_write;
    logic [31:0] alu_result, eff_addr, store_data;
    logic        stall, wb_valid, wb_we;
    logic [31:0] wb_data;
    logic        err_misalign, err_timeout;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(T), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_result   (alu_result),
        .eff_addr     (eff_addr),
        .store_data   (store_data),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_data      (wb_data),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    // ack_dly: BUS cycle index carrying the ack, negative for never.
    task automatic run_op(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [31:0] rdata,
                          input int ack_dly);
        logic        mem, mis, exp_we, exp_to, st;
        logic [31:0] exp_data;
        int          exp_n, nreq;
        mem      = rd | wr;
        st       = wr & ~rd;
        mis      = mem && (addr[1:0] != 2'b00);
        exp_to   = 1'b0;
        exp_we   = 1'b0;
        exp_data = 32'h0;
        exp_n    = 0;
        if (!mem) begin
            exp_we   = 1'b1;
            exp_data = alu;
        end else if (!mis) begin
            if (ack_dly >= 0 && ack_dly < T) begin
                exp_n    = ack_dly + 1;
                exp_we   = ~st;
                exp_data = st ? 32'h0 : rdata;
            end else begin
                exp_n  = T;
                exp_to = 1'b1;
            end
        end

        bus_ack    = 1'b0;
        in_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        eff_addr   = addr;
        alu_result = alu;
        store_data = sd;
        #1 chk("stall_accept", stall, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;

        nreq = 0;
        while (bus_req === 1'b1 && nreq <= T + 1) begin
            chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
            chk("bus_we", bus_we, st);
            if (st) chk("bus_wdata", bus_wdata, sd);
            chk("stall_bus", stall, 1);
            chk("wb_valid_bus", wb_valid, 0);
            bus_ack   = (nreq == ack_dly);
            bus_rdata = bus_ack ? rdata : $urandom;
            nreq++;
            @(posedge clk);
            @(negedge clk);
            bus_ack = 1'b0;
        end
        chk("bus_cycles", nreq, exp_n);
        chk("wb_valid", wb_valid, 1);
        chk("wb_we", wb_we, exp_we);
        chk("wb_data", wb_data, exp_data);
        chk("err_misalign", err_misalign, mis);
        chk("err_timeout", err_timeout, exp_to);
        chk("stall_done", stall, 0);
        chk("bus_req_done", bus_req, 0);
        @(negedge clk);
        chk("wb_valid_once", wb_valid, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b0;
            mem_read  = 1'($urandom);
            mem_write = 1'($urandom);
            bus_ack   = 1'($urandom);
            bus_rdata = $urandom;
            #1;
            chk("stall_idle", stall, 0);
            @(posedge clk);
            @(negedge clk);
            chk("wb_valid_idle", wb_valid, 0);
            chk("bus_req_idle", bus_req, 0);
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_result = 32'h0;
        eff_addr   = 32'h0;
        store_data = 32'h0;
        bus_rdata  = 32'h0;
        bus_ack    = 1'b0;
        #12;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 1'b0, 32'h0, 32'h0000_0007, 32'h0, 32'h0, -1);
        run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 3);
        run_op(1'b0, 1'b1, 32'h204, 32'h0, 32'h1234_5678, 32'h0, 0);
        run_op(1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 32'h0, 0);
        run_op(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 32'h5555_AAAA, -1);
        run_op(1'b1, 1'b0, 32'h304, 32'h0, 32'h0, 32'hCAFE_F00D, T - 1);
        run_op(1'b1, 1'b1, 32'h308, 32'h0, 32'h9999_9999, 32'h0BAD_CAFE, 1);
        idle_cycles(3);

        for (int i = 0; i < 60; i++) begin
            int          kind, dly;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            dly  = int'($urandom_range(0, 6));
            run_op(kind[0] | kind[1] & kind[0] | (kind == 3 ? 1'b1 : 1'b0)
                       | (kind == 1 ? 1'b1 : 1'b0),
                   (kind >= 2) ? 1'b1 : 1'b0,
                   a, $urandom, $urandom, $urandom, dly);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // Asynchronous reset during the second BUS cycle of a load
        in_valid  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        eff_addr  = 32'h400;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_bus_req", bus_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_bus_req", bus_req, 0);
        chk("rst_async_bus_addr", bus_addr, 0);
        chk("rst_async_wb_valid", wb_valid, 0);
        chk("rst_async_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        run_op(1'b0, 1'b1, 32'h408, 32'h0, 32'hA5A5_5A5A, 32'h0, 2);
        run_op(1'b0, 1'b0, 32'h0, 32'h1357_9BDF, 32'h0, 32'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
